// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported unified memory between three requesters.
//
// Requesters (each holds req plus its fields stable until it samples its ack):
//   if_*  core instruction fetch, read-only
//   d_*   core data access, read or write
//   x_*   external debug/DMA master, read or write
// Priority is data > fetch > external, except that once STARVE_MAX consecutive
// core grants have gone by while x_req was pending, the external master is
// forced in on the next decision.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-low reset
//   if_req/if_addr           fetch request in; if_rdata/if_ack out
//   d_req/d_we/d_addr/d_wdata data request in; d_rdata/d_ack out
//   x_req/x_we/x_addr/x_wdata external request in; x_rdata/x_ack out
//   resp_err                 1 alongside an ack when the transaction timed out
//   grant_id                 00 none, 01 fetch, 10 data, 11 external
//   m_req/m_we/m_addr/m_wdata memory request out, held until m_ack
//   m_rdata/m_ack            memory response in, m_rdata valid with m_ack
//
// A transaction walks IDLE -> ISSUE -> RESP, so it occupies at least three
// cycles. Every output is a flop.

module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    input  logic              x_req,
    input  logic              x_we,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_wdata,
    output logic [DATA_W-1:0] x_rdata,
    output logic              x_ack,
    output logic              resp_err,
    output logic [1:0]        grant_id,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [1:0] GID_NONE  = 2'b00;
    localparam logic [1:0] GID_FETCH = 2'b01;
    localparam logic [1:0] GID_DATA  = 2'b10;
    localparam logic [1:0] GID_EXT   = 2'b11;

    // Wide enough to hold TIMEOUT; one spare bit on the incremented value so
    // the compare against TIMEOUT never wraps.
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W:0] TO_LIM     = (TO_W + 1)'(TIMEOUT);
    localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_r, state_nxt_s;
    logic [1:0]        win_s;
    logic              starve_full_s;
    logic [TO_W:0]     to_inc_s;
    logic              to_hit_s;

    logic [3:0]        starve_cnt_r,  starve_cnt_nxt_s;
    logic [TO_W-1:0]   timeout_cnt_r, timeout_cnt_nxt_s;
    logic [1:0]        grant_r,       grant_nxt_s;
    logic              m_req_r,       m_req_nxt_s;
    logic              m_we_r,        m_we_nxt_s;
    logic [ADDR_W-1:0] m_addr_r,      m_addr_nxt_s;
    logic [DATA_W-1:0] m_wdata_r,     m_wdata_nxt_s;
    logic [DATA_W-1:0] if_rdata_r,    if_rdata_nxt_s;
    logic [DATA_W-1:0] d_rdata_r,     d_rdata_nxt_s;
    logic [DATA_W-1:0] x_rdata_r,     x_rdata_nxt_s;
    logic              if_ack_r,      if_ack_nxt_s;
    logic              d_ack_r,       d_ack_nxt_s;
    logic              x_ack_r,       x_ack_nxt_s;
    logic              resp_err_r,    resp_err_nxt_s;
    logic [DATA_W-1:0] resp_data_s;

    assign starve_full_s = (starve_cnt_r == STARVE_LIM);
    assign to_inc_s      = {1'b0, timeout_cnt_r} + {{TO_W{1'b0}}, 1'b1};
    assign to_hit_s      = (TIMEOUT != 0) && (to_inc_s == TO_LIM);
    // A timed-out transaction returns zero data.
    assign resp_data_s   = m_ack ? m_rdata : {DATA_W{1'b0}};

    // Pick the winner for the next grant decision (only used in IDLE).
    always_comb begin
        win_s = GID_NONE;
        if (x_req && starve_full_s) begin
            win_s = GID_EXT;
        end else if (d_req) begin
            win_s = GID_DATA;
        end else if (if_req) begin
            win_s = GID_FETCH;
        end else if (x_req) begin
            win_s = GID_EXT;
        end else begin
            win_s = GID_NONE;
        end
    end

    // Next-state and next-register values for the IDLE/ISSUE/RESP sequence.
    always_comb begin
        state_nxt_s       = state_r;
        starve_cnt_nxt_s  = starve_cnt_r;
        timeout_cnt_nxt_s = timeout_cnt_r;
        grant_nxt_s       = grant_r;
        m_req_nxt_s       = m_req_r;
        m_we_nxt_s        = m_we_r;
        m_addr_nxt_s      = m_addr_r;
        m_wdata_nxt_s     = m_wdata_r;
        if_rdata_nxt_s    = if_rdata_r;
        d_rdata_nxt_s     = d_rdata_r;
        x_rdata_nxt_s     = x_rdata_r;
        if_ack_nxt_s      = 1'b0;
        d_ack_nxt_s       = 1'b0;
        x_ack_nxt_s       = 1'b0;
        resp_err_nxt_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (win_s != GID_NONE) begin
                    state_nxt_s       = ST_ISSUE;
                    grant_nxt_s       = win_s;
                    m_req_nxt_s       = 1'b1;
                    timeout_cnt_nxt_s = {TO_W{1'b0}};
                    // The starvation count only measures an unbroken run of
                    // core grants while x is actually waiting.
                    if ((win_s == GID_EXT) || !x_req) begin
                        starve_cnt_nxt_s = 4'd0;
                    end else if (!starve_full_s) begin
                        starve_cnt_nxt_s = starve_cnt_r + 4'd1;
                    end else begin
                        starve_cnt_nxt_s = starve_cnt_r;
                    end
                    case (win_s)
                        GID_DATA: begin
                            m_we_nxt_s    = d_we;
                            m_addr_nxt_s  = d_addr;
                            m_wdata_nxt_s = d_wdata;
                        end
                        GID_FETCH: begin
                            m_we_nxt_s    = 1'b0;
                            m_addr_nxt_s  = if_addr;
                            m_wdata_nxt_s = {DATA_W{1'b0}};
                        end
                        GID_EXT: begin
                            m_we_nxt_s    = x_we;
                            m_addr_nxt_s  = x_addr;
                            m_wdata_nxt_s = x_wdata;
                        end
                        default: begin
                            m_we_nxt_s    = 1'b0;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = GID_NONE;
                end
            end
            ST_ISSUE: begin
                // m_ack takes precedence over a timeout in the same cycle.
                if (m_ack || to_hit_s) begin
                    state_nxt_s    = ST_RESP;
                    m_req_nxt_s    = 1'b0;
                    resp_err_nxt_s = !m_ack;
                    case (grant_r)
                        GID_FETCH: begin
                            if_ack_nxt_s   = 1'b1;
                            if_rdata_nxt_s = resp_data_s;
                        end
                        GID_DATA: begin
                            d_ack_nxt_s    = 1'b1;
                            d_rdata_nxt_s  = resp_data_s;
                        end
                        GID_EXT: begin
                            x_ack_nxt_s    = 1'b1;
                            x_rdata_nxt_s  = resp_data_s;
                        end
                        default: begin
                            resp_err_nxt_s = 1'b0;
                        end
                    endcase
                end else begin
                    timeout_cnt_nxt_s = to_inc_s[TO_W-1:0];
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = GID_NONE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = GID_NONE;
                m_req_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counters, memory-side fields and registered requester responses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_r  <= 4'd0;
            timeout_cnt_r <= {TO_W{1'b0}};
            grant_r       <= GID_NONE;
            m_req_r       <= 1'b0;
            m_we_r        <= 1'b0;
            m_addr_r      <= {ADDR_W{1'b0}};
            m_wdata_r     <= {DATA_W{1'b0}};
            if_rdata_r    <= {DATA_W{1'b0}};
            d_rdata_r     <= {DATA_W{1'b0}};
            x_rdata_r     <= {DATA_W{1'b0}};
            if_ack_r      <= 1'b0;
            d_ack_r       <= 1'b0;
            x_ack_r       <= 1'b0;
            resp_err_r    <= 1'b0;
        end else begin
            starve_cnt_r  <= starve_cnt_nxt_s;
            timeout_cnt_r <= timeout_cnt_nxt_s;
            grant_r       <= grant_nxt_s;
            m_req_r       <= m_req_nxt_s;
            m_we_r        <= m_we_nxt_s;
            m_addr_r      <= m_addr_nxt_s;
            m_wdata_r     <= m_wdata_nxt_s;
            if_rdata_r    <= if_rdata_nxt_s;
            d_rdata_r     <= d_rdata_nxt_s;
            x_rdata_r     <= x_rdata_nxt_s;
            if_ack_r      <= if_ack_nxt_s;
            d_ack_r       <= d_ack_nxt_s;
            x_ack_r       <= x_ack_nxt_s;
            resp_err_r    <= resp_err_nxt_s;
        end
    end

    assign if_rdata = if_rdata_r;
    assign if_ack   = if_ack_r;
    assign d_rdata  = d_rdata_r;
    assign d_ack    = d_ack_r;
    assign x_rdata  = x_rdata_r;
    assign x_ack    = x_ack_r;
    assign resp_err = resp_err_r;
    assign grant_id = grant_r;
    assign m_req    = m_req_r;
    assign m_we     = m_we_r;
    assign m_addr   = m_addr_r;
    assign m_wdata  = m_wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level
// reference model. Inputs change on the falling edge; the model advances on the
// rising edge and compares 1 time unit later.

module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 8;

    logic        clk, rst;
    logic        if_req, if_ack, d_req, d_we, d_ack, x_req, x_we, x_ack;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [31:0] x_addr, x_wdata, x_rdata;
    logic        resp_err, m_req, m_we, m_ack;
    logic [1:0]  grant_id;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int n_checks = 0;
    int n_errors = 0;

    // Memory responder controls: fixed_lat > 0 acks after that many request
    // cycles, 0 never acks, < 0 picks a random latency per transaction.
    int fixed_lat   = 1;
    logic inject_ack = 1'b0;

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_rdata(x_rdata), .x_ack(x_ack),
        .resp_err(resp_err), .grant_id(grant_id),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ack_of(input int who);
        case (who)
            1:       return if_ack;
            2:       return d_ack;
            3:       return x_ack;
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- memory responder ----------------
    logic [31:0] mem_arr [0:255];
    int mem_cnt, mem_lat;

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = {24'h123456, 8'(i)};
        m_ack = 1'b0; m_rdata = 32'h0; mem_cnt = 0; mem_lat = 1;
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            if (inject_ack) begin
                m_ack   = 1'b1;
                m_rdata = 32'hDEADBEEF;
            end else if (m_req === 1'b1) begin
                if (mem_cnt == 0) begin
                    if (fixed_lat >= 0) mem_lat = fixed_lat;
                    else begin
                        case ($urandom_range(0, 9))
                            0:       mem_lat = TIMEOUT;      // ack coincides with timeout
                            1:       mem_lat = TIMEOUT + 1;  // too late: times out
                            default: mem_lat = int'($urandom_range(1, 4));
                        endcase
                    end
                end
                mem_cnt++;
                if (mem_lat != 0 && mem_cnt == mem_lat) begin
                    m_ack = 1'b1;
                    if (m_we) begin
                        mem_arr[m_addr[7:0]] = m_wdata;
                        m_rdata = $urandom;
                    end else begin
                        m_rdata = mem_arr[m_addr[7:0]];
                    end
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    // mdl_phase: 0 no transaction, 1 waiting on memory, 2 responding.
    int          mdl_phase, mdl_win, mdl_starve, mdl_wait;
    logic        mdl_we, mdl_err;
    logic [31:0] mdl_addr, mdl_wdata;
    logic [31:0] mdl_rd [1:3];

    initial begin
        logic e_ack;
        mdl_phase = 0; mdl_win = 0; mdl_starve = 0; mdl_wait = 0;
        mdl_we = 1'b0; mdl_err = 1'b0; mdl_addr = 32'h0; mdl_wdata = 32'h0;
        for (int k = 1; k <= 3; k++) mdl_rd[k] = 32'h0;
        forever begin
            @(posedge clk);
            if (rst === 1'b0) begin
                mdl_phase = 0; mdl_starve = 0; mdl_err = 1'b0;
                for (int k = 1; k <= 3; k++) mdl_rd[k] = 32'h0;
            end else if (mdl_phase == 0) begin
                if (d_req || if_req || x_req) begin
                    if (x_req && mdl_starve == STARVE_MAX) mdl_win = 3;
                    else if (d_req)                        mdl_win = 2;
                    else if (if_req)                       mdl_win = 1;
                    else                                   mdl_win = 3;
                    if (mdl_win == 3 || !x_req)            mdl_starve = 0;
                    else if (mdl_starve < STARVE_MAX)      mdl_starve++;
                    case (mdl_win)
                        1: begin mdl_addr = if_addr; mdl_we = 1'b0; mdl_wdata = 32'h0;   end
                        2: begin mdl_addr = d_addr;  mdl_we = d_we; mdl_wdata = d_wdata; end
                        default: begin mdl_addr = x_addr; mdl_we = x_we; mdl_wdata = x_wdata; end
                    endcase
                    mdl_phase = 1;
                    mdl_wait  = 0;
                end
            end else if (mdl_phase == 1) begin
                mdl_wait++;
                if (m_ack) begin
                    mdl_rd[mdl_win] = m_rdata; mdl_err = 1'b0; mdl_phase = 2;
                end else if (mdl_wait == TIMEOUT) begin
                    mdl_rd[mdl_win] = 32'h0;   mdl_err = 1'b1; mdl_phase = 2;
                end
            end else begin
                mdl_phase = 0;
            end
            #1;
            chk("grant_id", 32'(grant_id), (mdl_phase == 0) ? 32'h0 : 32'(mdl_win));
            chk("m_req", 32'(m_req), 32'(mdl_phase == 1));
            chk("if_ack", 32'(if_ack), 32'(mdl_phase == 2 && mdl_win == 1));
            chk("d_ack",  32'(d_ack),  32'(mdl_phase == 2 && mdl_win == 2));
            chk("x_ack",  32'(x_ack),  32'(mdl_phase == 2 && mdl_win == 3));
            chk("if_rdata", if_rdata, mdl_rd[1]);
            chk("d_rdata",  d_rdata,  mdl_rd[2]);
            chk("x_rdata",  x_rdata,  mdl_rd[3]);
            if (mdl_phase == 1) begin
                chk("m_addr",  m_addr,  mdl_addr);
                chk("m_we",    32'(m_we), 32'(mdl_we));
                chk("m_wdata", m_wdata, mdl_wdata);
            end
            e_ack = (mdl_phase == 2);
            if (e_ack) chk("resp_err", 32'(resp_err), 32'(mdl_err));
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_ack(input int who, output int cyc);
        logic got;
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            cyc++;
            if (ack_of(who)) begin got = 1'b1; break; end
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL wait_ack: no ack for requester %0d after %0d cycles", who, cyc);
        end
    endtask

    // Let every outstanding request complete, dropping each on its ack.
    task automatic drain();
        int c;
        c = 0;
        while ((if_req || d_req || x_req) && c < 400) begin
            @(negedge clk);
            c++;
            if (if_ack) if_req = 1'b0;
            if (d_ack)  d_req  = 1'b0;
            if (x_ack)  x_req  = 1'b0;
        end
        n_checks++;
        if (if_req || d_req || x_req) begin
            n_errors++;
            $display("FAIL drain: requests still pending after %0d cycles", c);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc, core_acks, req_cycles;
        logic done;

        // 1. Reset held with every requester asking.
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1;  d_we = 1'b0; d_addr = 32'h10; d_wdata = 32'h0;
        x_req = 1'b1;  x_we = 1'b0; x_addr = 32'h30; x_wdata = 32'h0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_acks", {29'h0, if_ack, d_ack, x_ack}, 32'h0);
            chk("rst_m_req", 32'(m_req), 32'h0);
            chk("rst_grant", 32'(grant_id), 32'h0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("first_grant_data", 32'(grant_id), 32'h2);
        chk("first_grant_addr", m_addr, 32'h10);
        wait_ack(2, cyc); d_req = 1'b0;
        wait_ack(1, cyc); if_req = 1'b0;
        wait_ack(3, cyc); x_req = 1'b0;

        // 2. Data and fetch together, memory acks in the first request cycle.
        //    Ack shows up in the third cycle counting the request cycle.
        @(negedge clk);
        d_req = 1'b1; d_addr = 32'h44; if_req = 1'b1; if_addr = 32'h48;
        wait_ack(2, cyc);
        chk("prio_d_ack_lat", 32'(cyc), 32'd2);
        d_req = 1'b0;
        wait_ack(1, cyc);
        chk("prio_if_after_d", 32'(cyc), 32'd3);

        // 3. Starvation: x waits while the core keeps re-requesting.
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1;  d_addr = 32'h200;
        x_req = 1'b1;  x_we = 1'b0; x_addr = 32'h78;
        core_acks = 0; done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (x_ack) begin done = 1'b1; break; end
            if (d_ack)  begin core_acks++; d_addr = d_addr + 32'h4; end
            if (if_ack) begin core_acks++; if_addr = if_addr + 32'h4; end
        end
        chk("starve_x_done", 32'(done), 32'h1);
        chk("starve_core_grants", 32'(core_acks), 32'd4);
        chk("starve_x_rdata", x_rdata, 32'h12345678);
        x_req = 1'b0;
        drain();

        // 4. External write held on the memory side until m_ack.
        fixed_lat = 3;
        x_req = 1'b1; x_we = 1'b1; x_addr = 32'h100; x_wdata = 32'hCAFEF00D;
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_req) begin
                req_cycles++;
                chk("wr_m_we", 32'(m_we), 32'h1);
                chk("wr_m_addr", m_addr, 32'h100);
                chk("wr_m_wdata", m_wdata, 32'hCAFEF00D);
            end
            if (x_ack) begin
                chk("wr_resp_err", 32'(resp_err), 32'h0);
                break;
            end
        end
        chk("wr_req_cycles", 32'(req_cycles), 32'd3);
        x_req = 1'b0; x_we = 1'b0;

        // 5. Fetch that memory never answers times out after TIMEOUT cycles.
        @(negedge clk);
        fixed_lat = 0;
        if_req = 1'b1; if_addr = 32'h40;
        req_cycles = 0; done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_req) req_cycles++;
            if (if_ack) begin
                done = 1'b1;
                chk("to_resp_err", 32'(resp_err), 32'h1);
                chk("to_if_rdata", if_rdata, 32'h0);
                break;
            end
        end
        chk("to_ack_seen", 32'(done), 32'h1);
        chk("to_req_cycles", 32'(req_cycles), 32'd8);
        if_req = 1'b0;
        fixed_lat = 1;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h55;
        wait_ack(2, cyc);
        chk("after_to_err", 32'(resp_err), 32'h0);
        chk("after_to_rdata", d_rdata, 32'h12345655);
        d_req = 1'b0;

        // 6. Reset mid-request, with a stray m_ack the cycle after.
        fixed_lat = 0;
        @(negedge clk);
        d_req = 1'b1; d_addr = 32'h11;
        @(negedge clk);
        chk("mid_m_req_before", 32'(m_req), 32'h1);
        rst = 1'b0; d_req = 1'b0;
        #1 inject_ack = 1'b1;
        @(negedge clk);
        chk("mid_m_req_after", 32'(m_req), 32'h0);
        chk("mid_acks", {29'h0, if_ack, d_ack, x_ack}, 32'h0);
        chk("mid_grant", 32'(grant_id), 32'h0);
        #1 inject_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_idle_acks", {29'h0, if_ack, d_ack, x_ack}, 32'h0);
        chk("mid_idle_grant", 32'(grant_id), 32'h0);
        fixed_lat = 1;
        d_req = 1'b1; d_addr = 32'h22;
        wait_ack(2, cyc);
        chk("mid_new_err", 32'(resp_err), 32'h0);
        chk("mid_new_rdata", d_rdata, 32'h12345622);
        d_req = 1'b0;

        // 7. Random traffic with random memory latency.
        fixed_lat = -1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (if_req && if_ack) begin
                if ($urandom_range(0, 1) == 0) if_req = 1'b0;
                else if_addr = $urandom;
            end else if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (d_req && d_ack) begin
                if ($urandom_range(0, 1) == 0) d_req = 1'b0;
                else begin d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom; end
            end else if (!d_req && $urandom_range(0, 3) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
            end
            if (x_req && x_ack) begin
                if ($urandom_range(0, 1) == 0) x_req = 1'b0;
                else begin x_we = 1'($urandom_range(0, 1)); x_addr = $urandom; x_wdata = $urandom; end
            end else if (!x_req && $urandom_range(0, 2) == 0) begin
                x_req = 1'b1; x_we = 1'($urandom_range(0, 1)); x_addr = $urandom; x_wdata = $urandom;
            end
        end
        drain();
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between three requesters: core instruction fetch (if_*), core data access (d_*), and an external debug/DMA master (x_*).
- Sits between the RISC_V core's PC/instr and ALU_out/wr_data/mem_wr/rd_data pins and the memory.
- Fixed priority is data > fetch > external, with an anti-starvation counter for the external master and a transaction timeout.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_MAX, 4, consecutive core grants allowed while x_req is pending before x is forced (1..15).
- TIMEOUT, 255, cycles to wait for m_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch read data, valid with if_ack.
- if_ack  out  1  fetch done, 1-cycle pulse.
- d_req, d_we  in  1 each  data request; write enable.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  data write data.
- d_rdata  out  DATA_W  data read data.
- d_ack  out  1  data done pulse.
- x_req, x_we  in  1 each  external request; write enable.
- x_addr  in  ADDR_W  external address.
- x_wdata  in  DATA_W  external write data.
- x_rdata  out  DATA_W  external read data.
- x_ack  out  1  external done pulse.
- resp_err  out  1  qualifies the current ack; 1 = timed out.
- grant_id  out  2  00 none, 01 fetch, 10 data, 11 external.
- m_req, m_we  out  1 each  memory request; write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data, valid with m_ack.
- m_ack  in  1  memory done, 1-cycle pulse.

Behaviour:
- Reset: rst==0 at a clock edge puts the FSM in IDLE and clears all outputs, starve_cnt and timeout_cnt.
  - Reset mid-transaction: m_req is 0 the cycle after, and no ack is issued.
  - An m_ack arriving in IDLE is ignored.
- Requester handshake:
  - Requester holds req and its address/data/we stable until it samples ack=1.
  - It drops req, or presents a new request, on that same edge.
- Memory handshake:
  - Arbiter holds m_req and fields stable until m_ack=1 (any latency >= 1 cycle).
  - m_rdata is sampled on m_ack.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Any req asserted selects a winner. The winner's fields are registered into m_*, grant_id is set, and the FSM goes to ISSUE.
  - If no req is asserted, the FSM stays in IDLE with grant_id=00.
- ISSUE:
  - m_req=1 and timeout_cnt increments.
  - On m_ack: latch m_rdata into the winner's rdata register, set resp_err=0, go to RESP.
  - If TIMEOUT!=0 and timeout_cnt reaches TIMEOUT with no m_ack: drop m_req, set rdata=0 and resp_err=1, go to RESP.
  - If m_ack and the timeout coincide, m_ack wins.
- RESP:
  - The winner's ack is 1 for exactly this cycle, alongside rdata and resp_err; m_req=0. The FSM then returns to IDLE.
  - Minimum occupancy is 3 cycles per transaction (IDLE, ISSUE, RESP) when m_ack returns in the first ISSUE cycle.
- Arbitration in IDLE:
  - If x_req and starve_cnt==STARVE_MAX, grant x.
  - Otherwise grant in order d_req, then if_req, then x_req.
- starve_cnt:
  - Increments on a core (d or if) grant while x_req=1, saturating at STARVE_MAX.
  - Clears on an x grant, or on any grant decision with x_req=0.
- Fetch is read-only: m_we=0 and m_wdata=0 for fetch grants.
- rdata outputs hold their last value between acks.
- grant_id is non-zero in ISSUE and RESP only.
- timeout_cnt clears on entry to ISSUE.
- A requester that drops req before its ack still completes. The ack is issued and is the requester's to ignore.

Test Plan:
1. Reset: drive rst=0 for 2 cycles with all reqs=1, then release -> during reset all acks=0, m_req=0, grant_id=00; first grant is data.
2. Priority: d_req and if_req rise in the same cycle; memory acks after 1 cycle -> data granted first, d_ack 3 cycles after req; fetch is then granted and if_ack arrives 3 cycles after d_ack.
3. Starvation: STARVE_MAX=4, x_req held, d_req/if_req continuously re-requesting -> exactly 4 core grants, then x granted, with x_rdata = m_rdata (e.g. 0x12345678).
4. Write path: x_we=1, x_addr=0x100, x_wdata=0xCAFEF00D -> m_we=1, m_addr=0x100, m_wdata=0xCAFEF00D stable until m_ack; x_ack with resp_err=0.
5. Timeout: TIMEOUT=8, memory never acks a fetch -> m_req high 8 cycles then low; if_ack=1, resp_err=1, if_rdata=0; a following d_req is served normally.
6. Reset mid-ISSUE with m_ack asserted the next cycle -> no ack is issued, m_ack is ignored, FSM is in IDLE, and a new request after reset is served.
